// File: rtl/arrow_judge.sv
// -----------------------------------------------------------------------------
// arrow_judge
//
// Grades player button presses against the falling-arrow y position from the
// arrow mover. Each arrow is graded PERFECT, GOOD or MISS, and the block keeps
// a running score and combo. After an arrow is judged, the block drives the
// mover's reset (respawn) across at least one frame boundary so the arrow
// restarts from the top. It then waits one more frame before it accepts
// presses again.
//
// Ports:
//   clk          pixel clock, shared with the VGA counters and the mover
//   reset        asynchronous, active-low system reset
//   hc, vc       VGA horizontal / vertical counters (frame_tick at 0,0)
//   arrow_y      arrow y position from the mover
//   btn          raw asynchronous player button, active-high
//   respawn      drives the mover reset; high requests an arrow restart
//   judge        last result: 00 none, 01 GOOD, 10 PERFECT, 11 MISS
//   judge_valid  one-cycle pulse when judge updates
//   score        accumulated points, saturating at 16'hFFFF
//   combo        consecutive non-MISS count, saturating at 255
// -----------------------------------------------------------------------------
module arrow_judge #(
    parameter int TARGET_Y    = 400,
    parameter int PERFECT_TOL = 4,
    parameter int GOOD_TOL    = 12,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic [13:0] arrow_y,
    input  logic        btn,
    output logic        respawn,
    output logic [1:0]  judge,
    output logic        judge_valid,
    output logic [15:0] score,
    output logic [7:0]  combo
);

    typedef enum logic [1:0] {
        SETTLE    = 2'd0,
        TRACK     = 2'd1,
        HOLD_RESP = 2'd2
    } state_t;

    localparam logic [1:0] J_NONE    = 2'b00;
    localparam logic [1:0] J_GOOD    = 2'b01;
    localparam logic [1:0] J_PERFECT = 2'b10;
    localparam logic [1:0] J_MISS    = 2'b11;

    // Window bounds are folded into constants so that arrow_y is only ever
    // compared, never subtracted from. This avoids underflow near the top.
    localparam logic [13:0] P_LO = 14'(TARGET_Y - PERFECT_TOL);
    localparam logic [13:0] P_HI = 14'(TARGET_Y + PERFECT_TOL);
    localparam logic [13:0] G_LO = 14'(TARGET_Y - GOOD_TOL);
    localparam logic [13:0] G_HI = 14'(TARGET_Y + GOOD_TOL);

    localparam logic [15:0] PERFECT_ADD = 16'(PERFECT_PTS);
    localparam logic [15:0] GOOD_ADD    = 16'(GOOD_PTS);

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic        prev_reg;
    logic        press_reg;
    logic        respawn_reg, respawn_next;
    logic [1:0]  judge_reg, judge_next;
    logic        valid_reg, valid_next;
    logic [15:0] score_reg, score_next;
    logic [7:0]  combo_reg, combo_next;

    logic        frame_tick;
    logic        press_edge;
    logic        in_perfect;
    logic        in_good;
    logic        late;
    logic [1:0]  result;
    logic [15:0] pts;
    logic [16:0] score_sum;

    assign frame_tick = (hc == 10'd0) && (vc == 10'd0);
    assign press_edge = sync_reg[1] & ~prev_reg;

    assign in_perfect = (arrow_y >= P_LO) && (arrow_y <= P_HI);
    assign in_good    = (arrow_y >= G_LO) && (arrow_y <= G_HI);
    assign late       = (arrow_y > G_HI);

    // Button path: two-flop synchronizer, then a previous-value flop for rise
    // detection. The detected edge is registered once more. A rise first
    // captured at edge k is seen by the judge logic during the cycle after
    // edge k+2, and the judgement is registered at edge k+3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg  <= 2'b00;
            prev_reg  <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            prev_reg  <= sync_reg[1];
            press_reg <= press_edge;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= SETTLE;
            respawn_reg <= 1'b0;
            judge_reg   <= J_NONE;
            valid_reg   <= 1'b0;
            score_reg   <= 16'd0;
            combo_reg   <= 8'd0;
        end else begin
            state_reg   <= state_next;
            respawn_reg <= respawn_next;
            judge_reg   <= judge_next;
            valid_reg   <= valid_next;
            score_reg   <= score_next;
            combo_reg   <= combo_next;
        end
    end

    // Points for the current result. The 17-bit sum exposes the carry that
    // is used for clamping.
    always_comb begin
        pts = 16'd0;
        if (result == J_PERFECT) begin
            pts = PERFECT_ADD;
        end else if (result == J_GOOD) begin
            pts = GOOD_ADD;
        end
    end

    assign score_sum = {1'b0, score_reg} + {1'b0, pts};

    always_comb begin
        state_next   = state_reg;
        respawn_next = 1'b0;
        judge_next   = judge_reg;
        valid_next   = 1'b0;
        score_next   = score_reg;
        combo_next   = combo_reg;
        result       = J_NONE;

        case (state_reg)
            TRACK: begin
                // A press takes priority over a simultaneous late-arrow tick.
                // A press outside the GOOD window is dropped without penalty,
                // and it also suppresses the miss on that cycle.
                if (press_reg) begin
                    if (in_perfect) begin
                        result = J_PERFECT;
                    end else if (in_good) begin
                        result = J_GOOD;
                    end
                end else if (frame_tick && late) begin
                    result = J_MISS;
                end

                if (result != J_NONE) begin
                    state_next   = HOLD_RESP;
                    respawn_next = 1'b1;
                    judge_next   = result;
                    valid_next   = 1'b1;
                    if (result == J_MISS) begin
                        combo_next = 8'd0;
                    end else begin
                        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        combo_next = (combo_reg == 8'hFF) ? 8'hFF : combo_reg + 8'd1;
                    end
                end
            end

            HOLD_RESP: begin
                // Keep the mover in reset until it has seen a frame boundary.
                respawn_next = 1'b1;
                if (frame_tick) begin
                    respawn_next = 1'b0;
                    state_next   = SETTLE;
                end
            end

            SETTLE: begin
                // Skip the frame in which the mover reloads its start position.
                if (frame_tick) begin
                    state_next = TRACK;
                end
            end

            default: begin
                state_next = SETTLE;
            end
        endcase
    end

    assign respawn     = respawn_reg;
    assign judge       = judge_reg;
    assign judge_valid = valid_reg;
    assign score       = score_reg;
    assign combo       = combo_reg;

endmodule

// File: tb/tb_arrow_judge.sv
// -----------------------------------------------------------------------------
// tb_arrow_judge
//
// Directed testbench for arrow_judge. Stimulus is applied on the falling clock
// edge and outputs are sampled on the falling edge, away from the rising edge
// that the design uses.
// -----------------------------------------------------------------------------
module tb_arrow_judge;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [13:0] arrow_y;
    logic        btn;
    logic        respawn;
    logic [1:0]  judge;
    logic        judge_valid;
    logic [15:0] score;
    logic [7:0]  combo;

    int checks   = 0;
    int failures = 0;

    arrow_judge dut (
        .clk         (clk),
        .reset       (reset),
        .hc          (hc),
        .vc          (vc),
        .arrow_y     (arrow_y),
        .btn         (btn),
        .respawn     (respawn),
        .judge       (judge),
        .judge_valid (judge_valid),
        .score       (score),
        .combo       (combo)
    );

    always #5 clk = ~clk;

    // Stimulus helpers. Each one starts and ends just after a falling edge.
    task automatic idle(input int n);
        hc = 10'd1;
        vc = 10'd0;
        repeat (n) @(negedge clk);
    endtask

    // Apply exactly one rising edge with frame_tick asserted.
    task automatic frame();
        hc = 10'd0;
        vc = 10'd0;
        @(negedge clk);
        hc = 10'd1;
    endtask

    // Press at position y. Return right after edge k+3, which is the judgement edge.
    task automatic hit(input logic [13:0] y);
        arrow_y = y;
        btn     = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Release the button, then step through HOLD_RESP and SETTLE back into TRACK.
    task automatic recover();
        btn = 1'b0;
        idle(3);
        frame();
        frame();
    endtask

    task automatic test_reset();
        logic seen;
        reset   = 1'b0;
        btn     = 1'b0;
        hc      = 10'd1;
        vc      = 10'd0;
        arrow_y = 14'd200;
        repeat (2) @(negedge clk);
        checks++;
        if (respawn !== 1'b0) begin
            failures++;
            $display("FAIL reset_respawn got=%0b exp=0", respawn);
        end
        checks++;
        if ({judge, judge_valid, score, combo} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got judge=%0d valid=%0b score=%0d combo=%0d exp all 0",
                     judge, judge_valid, score, combo);
        end
        reset = 1'b1;
        // SETTLE after reset: a press in the PERFECT window must be ignored.
        arrow_y = 14'd402;
        btn     = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | judge_valid;
        end
        checks++;
        if (seen !== 1'b0 || score !== 16'd0) begin
            failures++;
            $display("FAIL settle_press_ignored got valid_seen=%0b score=%0d exp 0/0", seen, score);
        end
        btn     = 1'b0;
        idle(4);
        arrow_y = 14'd200;
        frame();
        frame();
        idle(2);
        checks++;
        if ({respawn, judge, judge_valid, score, combo} !== 28'd0) begin
            failures++;
            $display("FAIL track_idle got respawn=%0b judge=%0d valid=%0b score=%0d combo=%0d exp all 0",
                     respawn, judge, judge_valid, score, combo);
        end
    endtask

    task automatic test_perfect();
        logic seen;
        arrow_y = 14'd402;
        btn     = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (judge_valid !== 1'b0) begin
            failures++;
            $display("FAIL perfect_early_valid got=%0b exp=0 at edge k+2", judge_valid);
        end
        @(negedge clk);
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b10) begin
            failures++;
            $display("FAIL perfect_judge got valid=%0b judge=%0d exp 1/2", judge_valid, judge);
        end
        checks++;
        if (score !== 16'd3 || combo !== 8'd1 || respawn !== 1'b1) begin
            failures++;
            $display("FAIL perfect_score got score=%0d combo=%0d respawn=%0b exp 3/1/1",
                     score, combo, respawn);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | judge_valid;
        end
        checks++;
        if (seen !== 1'b0 || respawn !== 1'b1) begin
            failures++;
            $display("FAIL perfect_hold got extra_valid=%0b respawn=%0b exp 0/1", seen, respawn);
        end
        btn = 1'b0;
        idle(3);
        frame();
        checks++;
        if (respawn !== 1'b0) begin
            failures++;
            $display("FAIL respawn_drop got=%0b exp=0", respawn);
        end
        // SETTLE: a press is still ignored.
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | judge_valid;
        end
        checks++;
        if (seen !== 1'b0 || score !== 16'd3) begin
            failures++;
            $display("FAIL settle_ignore got valid_seen=%0b score=%0d exp 0/3", seen, score);
        end
        btn = 1'b0;
        idle(4);
        frame();
    endtask

    task automatic test_good_and_ignore();
        logic seen;
        hit(14'd390);
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b01 || score !== 16'd4 || combo !== 8'd2) begin
            failures++;
            $display("FAIL good_judge got valid=%0b judge=%0d score=%0d combo=%0d exp 1/1/4/2",
                     judge_valid, judge, score, combo);
        end
        recover();
        arrow_y = 14'd300;
        btn     = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | judge_valid;
        end
        checks++;
        if (seen !== 1'b0 || score !== 16'd4 || judge !== 2'b01 || respawn !== 1'b0) begin
            failures++;
            $display("FAIL out_of_window got valid_seen=%0b score=%0d judge=%0d respawn=%0b exp 0/4/1/0",
                     seen, score, judge, respawn);
        end
        btn = 1'b0;
        idle(4);
    endtask

    task automatic test_combo_miss();
        hit(14'd400);
        checks++;
        if (judge !== 2'b10 || score !== 16'd7 || combo !== 8'd3) begin
            failures++;
            $display("FAIL perfect_center got judge=%0d score=%0d combo=%0d exp 2/7/3", judge, score, combo);
        end
        recover();
        hit(14'd396);
        checks++;
        if (judge !== 2'b10 || score !== 16'd10 || combo !== 8'd4) begin
            failures++;
            $display("FAIL perfect_low_edge got judge=%0d score=%0d combo=%0d exp 2/10/4", judge, score, combo);
        end
        recover();
        hit(14'd404);
        checks++;
        if (judge !== 2'b10 || score !== 16'd13 || combo !== 8'd5) begin
            failures++;
            $display("FAIL perfect_high_edge got judge=%0d score=%0d combo=%0d exp 2/13/5", judge, score, combo);
        end
        recover();
        arrow_y = 14'd412;
        frame();
        checks++;
        if (judge_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_miss_at_412 got valid=%0b exp=0", judge_valid);
        end
        arrow_y = 14'd413;
        frame();
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b11 || combo !== 8'd0 || score !== 16'd13 || respawn !== 1'b1) begin
            failures++;
            $display("FAIL miss got valid=%0b judge=%0d combo=%0d score=%0d respawn=%0b exp 1/3/0/13/1",
                     judge_valid, judge, combo, score, respawn);
        end
        idle(1);
        checks++;
        if (judge_valid !== 1'b0) begin
            failures++;
            $display("FAIL miss_pulse_width got valid=%0b exp=0", judge_valid);
        end
        frame();
        frame();
    endtask

    task automatic test_simultaneous();
        logic seen;
        // The press reaches the judge logic on the same edge as frame_tick.
        arrow_y = 14'd412;
        btn     = 1'b1;
        repeat (3) @(negedge clk);
        hc = 10'd0;
        vc = 10'd0;
        @(negedge clk);
        hc = 10'd1;
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b01 || score !== 16'd14 || combo !== 8'd1) begin
            failures++;
            $display("FAIL simul_good got valid=%0b judge=%0d score=%0d combo=%0d exp 1/1/14/1",
                     judge_valid, judge, score, combo);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | judge_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL simul_single_valid got extra_valid=%0b exp=0", seen);
        end
        recover();
        // Late arrow with a simultaneous press: the press is evaluated and
        // ignored, and the miss is suppressed on that tick.
        arrow_y = 14'd413;
        btn     = 1'b1;
        repeat (3) @(negedge clk);
        hc = 10'd0;
        vc = 10'd0;
        @(negedge clk);
        hc = 10'd1;
        checks++;
        if (judge_valid !== 1'b0 || combo !== 8'd1) begin
            failures++;
            $display("FAIL simul_late_suppressed got valid=%0b combo=%0d exp 0/1", judge_valid, combo);
        end
        btn = 1'b0;
        idle(3);
        frame();
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b11 || combo !== 8'd0 || score !== 16'd14) begin
            failures++;
            $display("FAIL late_miss_after got valid=%0b judge=%0d combo=%0d score=%0d exp 1/3/0/14",
                     judge_valid, judge, combo, score);
        end
        recover();
    endtask

    task automatic test_saturation_and_async_reset();
        arrow_y = 14'd402;
        force dut.score_reg = 16'd65534;
        force dut.combo_reg = 8'd255;
        @(negedge clk);
        release dut.score_reg;
        release dut.combo_reg;
        hit(14'd402);
        checks++;
        if (judge_valid !== 1'b1 || judge !== 2'b10) begin
            failures++;
            $display("FAIL sat_judge got valid=%0b judge=%0d exp 1/2", judge_valid, judge);
        end
        checks++;
        if (score !== 16'hFFFF || combo !== 8'd255) begin
            failures++;
            $display("FAIL saturation got score=%0d combo=%0d exp 65535/255", score, combo);
        end
        checks++;
        if (respawn !== 1'b1) begin
            failures++;
            $display("FAIL sat_respawn got=%0b exp=1", respawn);
        end
        // Assert reset between clock edges while in HOLD_RESP.
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (respawn !== 1'b0) begin
            failures++;
            $display("FAIL async_respawn got=%0b exp=0", respawn);
        end
        checks++;
        if ({judge, judge_valid, score, combo} !== 27'd0) begin
            failures++;
            $display("FAIL async_clear got judge=%0d valid=%0b score=%0d combo=%0d exp all 0",
                     judge, judge_valid, score, combo);
        end
        btn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(2);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_perfect();
        test_good_and_ignore();
        test_combo_miss();
        test_simultaneous();
        test_saturation_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
